// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Purpose  : Arbitrates between the data-path (d) and control-path (i) L1
//            caches for a single memory request port. Every granted request
//            is recorded in an in-order tracking queue so that memory
//            responses can be steered back to the requester that issued them.
// Ports    : i_clk / i_rst          - clock, synchronous active-high reset
//            i_{d,i}_req_*          - requester request channels
//            o_{d,i}_req_ready      - grant strobe (combinational, IDLE only)
//            o_req_mem_* / i_req_mem_ready - registered memory request channel
//            i_resp_mem_*           - memory response channel
//            o_{d,i}_resp_valid, o_resp_* - routed response outputs
// Macro    : CACHE_ARB_ROUND_ROBIN_EN - alternate grants between requesters
//            when both request together; otherwise DATA_PATH has fixed
//            priority.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
   parameter int QDEPTH                 = 2,
   parameter int REQ_MEM_TYPE_BITS      = 3,
   parameter int CFG_CPU_ADDR_BITS      = 32,
   parameter int L1CACHE_BYTES_PER_LINE = 32,
   parameter int L1CACHE_LINE_BITS      = 256
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   // data-path requester
   input  logic                              i_d_req_valid,
   output logic                              o_d_req_ready,
   input  logic [REQ_MEM_TYPE_BITS-1:0]      i_d_req_type,
   input  logic [2:0]                        i_d_req_size,
   input  logic [CFG_CPU_ADDR_BITS-1:0]      i_d_req_addr,
   input  logic [L1CACHE_BYTES_PER_LINE-1:0] i_d_req_strob,
   input  logic [L1CACHE_LINE_BITS-1:0]      i_d_req_wdata,
   // control-path requester
   input  logic                              i_i_req_valid,
   output logic                              o_i_req_ready,
   input  logic [REQ_MEM_TYPE_BITS-1:0]      i_i_req_type,
   input  logic [2:0]                        i_i_req_size,
   input  logic [CFG_CPU_ADDR_BITS-1:0]      i_i_req_addr,
   input  logic [L1CACHE_BYTES_PER_LINE-1:0] i_i_req_strob,
   input  logic [L1CACHE_LINE_BITS-1:0]      i_i_req_wdata,
   // memory request
   output logic                              o_req_mem_valid,
   input  logic                              i_req_mem_ready,
   output logic [REQ_MEM_TYPE_BITS-1:0]      o_req_mem_type,
   output logic [2:0]                        o_req_mem_size,
   output logic [CFG_CPU_ADDR_BITS-1:0]      o_req_mem_addr,
   output logic [L1CACHE_BYTES_PER_LINE-1:0] o_req_mem_strob,
   output logic [L1CACHE_LINE_BITS-1:0]      o_req_mem_wdata,
   output logic                              o_req_mem_path,
   // memory response
   input  logic                              i_resp_mem_valid,
   input  logic [L1CACHE_LINE_BITS-1:0]      i_resp_mem_data,
   input  logic                              i_resp_mem_err,
   output logic                              o_d_resp_valid,
   output logic                              o_i_resp_valid,
   output logic [L1CACHE_LINE_BITS-1:0]      o_resp_data,
   output logic                              o_resp_err,
   output logic [CFG_CPU_ADDR_BITS-1:0]      o_resp_addr,
   output logic                              o_resp_unexpected
);

   localparam int QUEUE_WIDTH = CFG_CPU_ADDR_BITS + REQ_MEM_TYPE_BITS + 3 + 1;
   localparam int PTR_W       = $clog2(QDEPTH);
   localparam int CNT_W       = $clog2(QDEPTH + 1);

   localparam logic [0:0] c_state_idle = 1'b0;
   localparam logic [0:0] c_state_req  = 1'b1;
   localparam logic       c_data_path  = 1'b0;
   localparam logic       c_ctrl_path  = 1'b1;

   logic [0:0]                        r_state;
   logic [PTR_W-1:0]                  r_wr_ptr;
   logic [PTR_W-1:0]                  r_rd_ptr;
   logic [CNT_W-1:0]                  r_count;
   logic [QUEUE_WIDTH-1:0]            r_queue [QDEPTH];
`ifdef CACHE_ARB_ROUND_ROBIN_EN
   logic                              r_rr_prio;   // path that wins the next tie
`endif

   logic                              w_full;
   logic                              w_empty;
   logic                              w_grant;
   logic                              w_grant_path;
   logic                              w_push;
   logic                              w_pop;
   logic [REQ_MEM_TYPE_BITS-1:0]      w_sel_type;
   logic [2:0]                        w_sel_size;
   logic [CFG_CPU_ADDR_BITS-1:0]      w_sel_addr;
   logic [L1CACHE_BYTES_PER_LINE-1:0] w_sel_strob;
   logic [L1CACHE_LINE_BITS-1:0]      w_sel_wdata;
   logic [QUEUE_WIDTH-1:0]            w_head;
   logic                              w_head_path;
   logic [QUEUE_WIDTH-CFG_CPU_ADDR_BITS-2:0] w_unused_head_meta;

   assign w_full  = (r_count == CNT_W'(QDEPTH));
   assign w_empty = (r_count == '0);

   // Requester selection; only meaningful when w_grant is set.
   always_comb begin
      w_grant = (r_state == c_state_idle) && (i_d_req_valid || i_i_req_valid)
                && !w_full && !i_rst;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      if (i_d_req_valid && i_i_req_valid) begin
         w_grant_path = r_rr_prio;
      end else begin
         w_grant_path = i_i_req_valid ? c_ctrl_path : c_data_path;
      end
`else
      w_grant_path = (i_i_req_valid && !i_d_req_valid) ? c_ctrl_path : c_data_path;
`endif
   end

   always_comb begin
      if (w_grant_path == c_ctrl_path) begin
         w_sel_type  = i_i_req_type;
         w_sel_size  = i_i_req_size;
         w_sel_addr  = i_i_req_addr;
         w_sel_strob = i_i_req_strob;
         w_sel_wdata = i_i_req_wdata;
      end else begin
         w_sel_type  = i_d_req_type;
         w_sel_size  = i_d_req_size;
         w_sel_addr  = i_d_req_addr;
         w_sel_strob = i_d_req_strob;
         w_sel_wdata = i_d_req_wdata;
      end
   end

   assign o_d_req_ready = w_grant && (w_grant_path == c_data_path);
   assign o_i_req_ready = w_grant && (w_grant_path == c_ctrl_path);

   // Queue entry layout: {addr, type, size, path}, path in bit 0.
   assign w_push             = w_grant;
   assign w_pop              = i_resp_mem_valid && !w_empty && !i_rst;
   assign w_head             = r_queue[r_rd_ptr];
   assign w_head_path        = w_head[0];
   assign w_unused_head_meta = w_head[QUEUE_WIDTH-CFG_CPU_ADDR_BITS-1:1];

   assign o_d_resp_valid    = w_pop && (w_head_path == c_data_path);
   assign o_i_resp_valid    = w_pop && (w_head_path == c_ctrl_path);
   assign o_resp_unexpected = i_resp_mem_valid && w_empty && !i_rst;
   assign o_resp_data       = i_resp_mem_data;
   assign o_resp_err        = i_resp_mem_err;
   assign o_resp_addr       = w_head[QUEUE_WIDTH-1 -: CFG_CPU_ADDR_BITS];

   // Queue storage carries no reset; validity is governed by r_count.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_queue[r_wr_ptr] <= {w_sel_addr, w_sel_type, w_sel_size, w_grant_path};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= c_state_idle;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_count         <= '0;
         o_req_mem_valid <= 1'b0;
         o_req_mem_type  <= '0;
         o_req_mem_size  <= '0;
         o_req_mem_addr  <= '0;
         o_req_mem_strob <= '0;
         o_req_mem_wdata <= '0;
         o_req_mem_path  <= c_data_path;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
         r_rr_prio       <= c_data_path;
`endif
      end else begin
         case (r_state)
            c_state_idle: begin
               if (w_grant) begin
                  o_req_mem_valid <= 1'b1;
                  o_req_mem_type  <= w_sel_type;
                  o_req_mem_size  <= w_sel_size;
                  o_req_mem_addr  <= w_sel_addr;
                  o_req_mem_strob <= w_sel_strob;
                  o_req_mem_wdata <= w_sel_wdata;
                  o_req_mem_path  <= w_grant_path;
                  r_state         <= c_state_req;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                  r_rr_prio       <= ~w_grant_path;
`endif
               end
            end
            default: begin
               // Fields hold until memory accepts.
               if (i_req_mem_ready) begin
                  o_req_mem_valid <= 1'b0;
                  r_state         <= c_state_idle;
               end
            end
         endcase

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire
